stacked_program_counter: RTL
============================

Name: stacked_program_counter

Overview:
- Parametrised next-generation program counter for the bus-based CPU.
- Adds a hardware return-address stack (call/return), signed relative branch, a configurable reset vector and stack status flags.
- Sits on the shared tri-state CPU bus and is driven by the control sequencer, alongside the memory address register.

Parameters:
DATA_WIDTH, 8, width of the shared CPU bus
ADDRESS_WIDTH, 8, counter width; must satisfy 1 <= ADDRESS_WIDTH <= DATA_WIDTH
STACK_DEPTH, 4, number of return-address entries; must be >= 1
RESET_VECTOR, 0, counter value after reset, truncated to ADDRESS_WIDTH

Ports:
i_CLOCK  input  1  system clock; all state changes on the rising edge
i_CLEAR_n  input  1  asynchronous active-low reset
BUS  inout  DATA_WIDTH  main CPU bus
i_COUNT_ENABLE  input  1  increment the counter
i_JUMP  input  1  load the counter from the bus
i_CALL  input  1  push the return address, then load the counter from the bus
i_RETURN  input  1  pop the stack into the counter
i_BRANCH_REL  input  1  add the signed bus value to the counter
i_OUTPUT  input  1  drive the counter onto the bus
o_ADDRESS  output  ADDRESS_WIDTH  current counter value, always visible
o_DEPTH  output  clog2(STACK_DEPTH+1)  number of occupied stack entries
o_STACK_EMPTY  output  1  high when o_DEPTH == 0
o_STACK_FULL  output  1  high when o_DEPTH == STACK_DEPTH
o_STACK_FAULT  output  1  sticky overflow/underflow flag

Behaviour:
- Reset, asynchronous while i_CLEAR_n is low:
  - counter = RESET_VECTOR, depth = 0, fault = 0, so o_STACK_EMPTY = 1 and o_STACK_FULL = 0.
  - Stack entry contents are don't-care.
  - Reset overrides any operation in flight; the first edge after release acts normally.
- Priority on each rising edge: JUMP > CALL > RETURN > BRANCH_REL > COUNT_ENABLE. Exactly one operation executes per cycle; lower-priority requests that cycle are dropped.
- Bus loads (JUMP, CALL, BRANCH_REL) are ignored while i_OUTPUT is high. Resolution then falls through to RETURN, then COUNT_ENABLE.
- JUMP: counter <= BUS[ADDRESS_WIDTH-1:0]. The stack is unchanged.
- CALL, not full:
  - push (counter + 1) mod 2^ADDRESS_WIDTH; depth += 1.
  - counter <= BUS[ADDRESS_WIDTH-1:0].
- CALL, full: fault <= 1; counter, stack and depth hold.
- RETURN, not empty: counter <= top entry; depth -= 1 (LIFO).
- RETURN, empty: fault <= 1; counter holds.
- BRANCH_REL:
  - counter <= (counter + sign-extended BUS[DATA_WIDTH-1:0]) mod 2^ADDRESS_WIDTH.
  - The offset's sign bit is BUS[DATA_WIDTH-1]; wraps both ways.
- COUNT_ENABLE: counter <= counter + 1; all-ones wraps to 0.
- No operation: everything holds.
- Fault stays set until reset; it does not block further operations.
- Latency:
  - New counter value appears on o_ADDRESS and the bus one edge after the request.
  - Flags and depth update on the same edge as the operation.
- Bus drive:
  - When i_OUTPUT = 1, BUS[ADDRESS_WIDTH-1:0] = counter and BUS[DATA_WIDTH-1:ADDRESS_WIDTH] = 0 (when wider).
  - Otherwise every bit is high-Z.
  - The drive is combinational from i_OUTPUT and the counter.
- Stack storage: registers indexed by depth; no bus-visible access.

Test Plan:
- Reset with RESET_VECTOR=0x10, i_CLEAR_n pulsed mid-count -> o_ADDRESS=0x10 immediately, o_DEPTH=0, EMPTY=1, FAULT=0; BUS high-Z with i_OUTPUT=0.
- Counter at 0xFE, COUNT_ENABLE for 3 cycles -> 0xFF, 0x00, 0x01; i_OUTPUT=1 -> BUS=0x01.
- Counter 0x05, CALL with BUS=0x40; CALL with BUS=0x80; then 2x RETURN -> 0x40, 0x80, 0x41, 0x06; depth 1, 2, 1, 0.
- STACK_DEPTH=4, 5 consecutive CALLs -> FULL after the 4th; 5th sets FAULT, counter and depth hold. RETURN on an empty stack -> FAULT=1, counter holds.
- Counter 0x10, BRANCH_REL BUS=0xFC -> 0x0C; counter 0xFE, BRANCH_REL BUS=0x03 -> 0x01.
- JUMP+CALL+COUNT together with BUS=0x33 -> counter 0x33, depth unchanged. JUMP with i_OUTPUT=1 and COUNT_ENABLE=1 -> counter increments only.

Source files
------------

// File: rtl/stacked_program_counter.sv
// Program counter with a hardware return-address stack for the bus-based CPU.
// Supports increment, absolute jump, call/return through a LIFO of return
// addresses, signed relative branch and tri-state drive onto the shared bus.
// Stack status (depth, empty, full) and a sticky overflow/underflow fault are
// exported for the control sequencer.
// ADDRESS_WIDTH must satisfy 1 <= ADDRESS_WIDTH <= DATA_WIDTH and STACK_DEPTH >= 1.
module stacked_program_counter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STACK_DEPTH   = 4,
    parameter int RESET_VECTOR  = 0
) (
    input  logic                                 i_CLOCK,
    input  logic                                 i_CLEAR_n,
    inout  wire  [DATA_WIDTH-1:0]                BUS,
    input  logic                                 i_COUNT_ENABLE,
    input  logic                                 i_JUMP,
    input  logic                                 i_CALL,
    input  logic                                 i_RETURN,
    input  logic                                 i_BRANCH_REL,
    input  logic                                 i_OUTPUT,
    output logic [ADDRESS_WIDTH-1:0]             o_ADDRESS,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     o_DEPTH,
    output logic                                 o_STACK_EMPTY,
    output logic                                 o_STACK_FULL,
    output logic                                 o_STACK_FAULT
);

    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_ADDR = ADDRESS_WIDTH'(RESET_VECTOR);
    localparam logic [DEPTH_WIDTH-1:0]   FULL_DEPTH = DEPTH_WIDTH'(STACK_DEPTH);

    logic [ADDRESS_WIDTH-1:0] counter_reg;
    logic [ADDRESS_WIDTH-1:0] counter_next;
    logic [DEPTH_WIDTH-1:0]   depth_reg;
    logic [DEPTH_WIDTH-1:0]   depth_next;
    logic                     fault_reg;
    logic                     fault_next;

    logic                     push_en;
    logic                     stack_empty;
    logic                     stack_full;
    logic                     load_allowed;
    logic [ADDRESS_WIDTH-1:0] bus_addr;
    logic [ADDRESS_WIDTH-1:0] return_addr;
    logic [ADDRESS_WIDTH-1:0] top_entry;
    logic [ADDRESS_WIDTH-1:0] stack_entries [STACK_DEPTH];

    assign stack_empty  = (depth_reg == '0);
    assign stack_full   = (depth_reg == FULL_DEPTH);
    // The counter itself is on the bus while i_OUTPUT is high, so loading from
    // the bus in that cycle would just be a feedback loop; such loads are dropped.
    assign load_allowed = !i_OUTPUT;
    assign bus_addr     = BUS[ADDRESS_WIDTH-1:0];
    assign return_addr  = counter_reg + ADDRESS_WIDTH'(1);

    // One storage slot per stack level; slot N is written when depth is N.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
        logic [ADDRESS_WIDTH-1:0] entry_reg;

        // Capture the return address when this slot is the next free one
        always_ff @(posedge i_CLOCK) begin
            if (push_en && (depth_reg == DEPTH_WIDTH'(gi))) begin
                entry_reg <= return_addr;
            end
        end

        assign stack_entries[gi] = entry_reg;
    end

    // Select the most recently pushed entry (slot depth-1)
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_reg == DEPTH_WIDTH'(i + 1)) begin
                top_entry = stack_entries[i];
            end
        end
    end

    // Resolve the single winning operation by priority and form next state
    always_comb begin
        counter_next = counter_reg;
        depth_next   = depth_reg;
        fault_next   = fault_reg;
        push_en      = 1'b0;

        if (i_JUMP && load_allowed) begin
            counter_next = bus_addr;
        end else if (i_CALL && load_allowed) begin
            if (stack_full) begin
                fault_next = 1'b1;
            end else begin
                push_en      = 1'b1;
                depth_next   = depth_reg + DEPTH_WIDTH'(1);
                counter_next = bus_addr;
            end
        end else if (i_RETURN) begin
            if (stack_empty) begin
                fault_next = 1'b1;
            end else begin
                depth_next   = depth_reg - DEPTH_WIDTH'(1);
                counter_next = top_entry;
            end
        end else if (i_BRANCH_REL && load_allowed) begin
            // Adding the full bus word and truncating equals adding the
            // sign-extended offset modulo 2^ADDRESS_WIDTH.
            counter_next = ADDRESS_WIDTH'(DATA_WIDTH'(counter_reg) + BUS);
        end else if (i_COUNT_ENABLE) begin
            counter_next = counter_reg + ADDRESS_WIDTH'(1);
        end
    end

    // Counter, stack depth and sticky fault, cleared asynchronously
    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            counter_reg <= RESET_ADDR;
            depth_reg   <= '0;
            fault_reg   <= 1'b0;
        end else begin
            counter_reg <= counter_next;
            depth_reg   <= depth_next;
            fault_reg   <= fault_next;
        end
    end

    assign BUS           = i_OUTPUT ? DATA_WIDTH'(counter_reg) : 'z;
    assign o_ADDRESS     = counter_reg;
    assign o_DEPTH       = depth_reg;
    assign o_STACK_EMPTY = stack_empty;
    assign o_STACK_FULL  = stack_full;
    assign o_STACK_FAULT = fault_reg;

endmodule
